// File: rtl/rr_sched_pkg.sv
// Shared constants, state type and round-robin winner search for the grant scheduler.
// Combinational helpers only; no state lives here.
package rr_sched_pkg;

  localparam int N_REQ = 10;
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  // First set request after ptr, wrapping 9 -> 0; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                              input logic [N_REQ-1:0] req);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder_sv.sv
// Index to one-hot decoder, zero latency, no flow control.
// Indices beyond the requester range drive all ones, so callers must gate the result.
module decoder_sv
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] dec_o
);

  always_comb begin
    dec_o = '1;
    if (idx_i < IDX_W'(N_REQ)) begin
      dec_o = N_REQ'(1) << idx_i;
    end
  end

endmodule

// File: rtl/rr_grant_sched_sv.sv
// Round-robin owner of one shared resource across 10 requesters; grant one edge after request.
// A grant is held until release, withdrawal or QUANTUM cycles, then one IDLE cycle follows.
module rr_grant_sched_sv
  import rr_sched_pkg::*;
#(
  parameter int QUANTUM = 16
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iEN,
  input  logic [N_REQ-1:0] iREQ,
  input  logic             iDONE,
  output logic             oGNT_VLD,
  output logic [IDX_W-1:0] oGNT_IDX,
  output logic [N_REQ-1:0] oGNT,
  output logic             oTIMEOUT
);

  localparam int              CNT_W    = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [IDX_W-1:0] win;
  logic [N_REQ-1:0] gnt_raw;

  assign win = rr_next(ptr_q, iREQ);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEN && (|iREQ)) begin
          state_d = GRANT;
          idx_d   = win;
          ptr_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // Release beats withdrawal beats timeout; only the timeout pulses.
        if (iDONE) begin
          state_d = IDLE;
        end else if (!iREQ[idx_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  decoder_sv u_dec (
    .idx_i (idx_q),
    .dec_o (gnt_raw)
  );

  assign oGNT_VLD = (state_q == GRANT);
  assign oGNT_IDX = idx_q;
  assign oGNT     = oGNT_VLD ? gnt_raw : '0;
  assign oTIMEOUT = tmo_q;

endmodule

// File: tb/tb_rr_grant_sched_sv.sv
// Scoreboard bench for rr_grant_sched_sv: directed scenarios then random traffic,
// predicted per-cycle outputs queued by the driver and checked by an independent monitor.
module tb_rr_grant_sched_sv;

  localparam int QUANTUM = 16;

  logic       iCLK;
  logic       iRSTn;
  logic       iEN;
  logic [9:0] iREQ;
  logic       iDONE;
  logic       oGNT_VLD;
  logic [3:0] oGNT_IDX;
  logic [9:0] oGNT;
  logic       oTIMEOUT;

  rr_grant_sched_sv #(.QUANTUM(QUANTUM)) dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iEN      (iEN),
    .iREQ     (iREQ),
    .iDONE    (iDONE),
    .oGNT_VLD (oGNT_VLD),
    .oGNT_IDX (oGNT_IDX),
    .oGNT     (oGNT),
    .oTIMEOUT (oTIMEOUT)
  );

  typedef struct {
    int         cyc;
    logic       vld;
    logic [3:0] idx;
    logic [9:0] gnt;
    logic       to;
  } exp_t;

  exp_t expq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: who holds the resource, for how many cycles, who won last.
  int   m_last   = 9;
  int   m_holder = 0;
  int   m_held   = 0;
  bit   m_busy   = 0;
  bit   m_to     = 0;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_last = 9; m_holder = 0; m_held = 0; m_busy = 0; m_to = 0;
  endtask

  task automatic model_step(input bit en, input logic [9:0] req, input bit done);
    int c;
    m_to = 0;
    if (m_busy) begin
      if (done || !req[m_holder[3:0]]) begin
        m_busy = 0;
      end else if (m_held == QUANTUM) begin
        m_busy = 0;
        m_to   = 1;
      end else begin
        m_held++;
      end
    end else if (en && req != 10'd0) begin
      for (int k = 1; k <= 10; k++) begin
        c = (m_last + k) % 10;
        if (req[c[3:0]]) begin
          m_holder = c;
          break;
        end
      end
      m_last = m_holder;
      m_busy = 1;
      m_held = 1;
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the coming edge.
  task automatic step(input bit en, input logic [9:0] req, input bit done);
    exp_t e;
    iEN = en; iREQ = req; iDONE = done;
    model_step(en, req, done);
    e.cyc = cyc + 1;
    e.vld = m_busy;
    e.idx = m_holder[3:0];
    e.gnt = m_busy ? (10'd1 << m_holder) : 10'd0;
    e.to  = m_to;
    expq.push_back(e);
    @(posedge iCLK);
    #1;
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      if (e.cyc < cyc) begin
        chk("sb_missed_slot", 32'(e.cyc), 32'(cyc));
      end else begin
        chk("gnt_vld", 32'(oGNT_VLD), 32'(e.vld));
        chk("gnt_idx", 32'(oGNT_IDX), 32'(e.idx));
        chk("gnt_vec", 32'(oGNT),     32'(e.gnt));
        chk("timeout", 32'(oTIMEOUT), 32'(e.to));
      end
    end
  end

  initial begin
    iRSTn = 1'b0; iEN = 1'b0; iREQ = '0; iDONE = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_vld", 32'(oGNT_VLD), 32'd0);
    chk("rst_idx", 32'(oGNT_IDX), 32'd0);
    chk("rst_gnt", 32'(oGNT),     32'd0);
    chk("rst_to",  32'(oTIMEOUT), 32'd0);
    iRSTn = 1'b1;

    // First grant from reset, then iEN low with requests pending.
    step(1, 10'h001, 0);
    step(1, 10'h001, 1);
    step(0, 10'h3FF, 0);
    step(0, 10'h3FF, 0);

    // Full round robin with one-cycle holds.
    for (int g = 0; g < 11; g++) begin
      step(1, 10'h3FF, 0);
      step(1, 10'h3FF, 1);
    end

    // Park the pointer at 8, then 9 -> 0 wrap.
    step(1, 10'h100, 0);
    step(1, 10'h100, 1);
    for (int g = 0; g < 2; g++) begin
      step(1, 10'h201, 0);
      step(1, 10'h201, 1);
    end

    // Hold with no release: timeout pulse, bubble, re-grant of the sole requester.
    for (int s = 0; s < QUANTUM + 4; s++) step(1, 10'h010, 0);
    step(1, 10'h010, 1);
    step(0, 10'h000, 0);

    // Release on the last allowed cycle wins over the timeout.
    step(1, 10'h020, 0);
    for (int s = 0; s < QUANTUM - 1; s++) step(1, 10'h020, 0);
    step(1, 10'h020, 1);
    step(0, 10'h000, 0);

    // Holder withdraws its request.
    step(1, 10'h0C0, 0);
    step(1, 10'h0C0, 0);
    step(1, 10'h040, 0);
    step(1, 10'h080, 0);
    step(1, 10'h080, 1);

    // Asynchronous reset close to a timeout.
    step(1, 10'h008, 0);
    for (int s = 0; s < QUANTUM - 2; s++) step(1, 10'h008, 0);
    @(negedge iCLK);
    #1;
    iRSTn = 1'b0;
    #1;
    chk("arst_gnt", 32'(oGNT),     32'd0);
    chk("arst_vld", 32'(oGNT_VLD), 32'd0);
    chk("arst_to",  32'(oTIMEOUT), 32'd0);
    chk("arst_idx", 32'(oGNT_IDX), 32'd0);
    model_reset();
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    step(1, 10'h200, 0);
    step(1, 10'h200, 1);

    // Random traffic.
    begin
      logic [9:0] rq;
      bit         en;
      bit         dn;
      rq = 10'h3FF;
      for (int s = 0; s < 600; s++) begin
        if ($urandom_range(0, 3) == 0) rq = 10'($urandom_range(0, 1023));
        en = ($urandom_range(0, 9) != 0);
        dn = ($urandom_range(0, 11) == 0);
        step(en, rq, dn);
      end
    end

    step(0, 10'h000, 0);
    step(0, 10'h000, 0);
    @(negedge iCLK);
    #1;
    chk("sb_drain", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
